// File: rtl/ysyx_22041461_rf_pkg.sv
// Shared constants and types for the register-file write scheduler.
// Build option YSYX_22041461_RF_SCHED_BYPASS_EN is consumed by ysyx_22041461_rf_sched.
package ysyx_22041461_rf_pkg;

    localparam int XLEN  = 64;
    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 32;

    localparam logic [3:0] RF_SEL_HOLD = 4'b0000;
    localparam logic [3:0] RF_SEL_DEST = 4'b0001;

    typedef enum logic {
        REQ_EXU = 1'b0,
        REQ_LSU = 1'b1
    } req_e;

endpackage

// File: rtl/ysyx_22041461_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to the
// pointer's requester and flips the pointer to the other one.
module ysyx_22041461_rr_arb2
    import ysyx_22041461_rf_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req_exu,
    input  logic i_req_lsu,
    output logic o_gnt_exu,
    output logic o_gnt_lsu
);

    req_e r_ptr;
    logic w_tie;

    assign w_tie = i_req_exu && i_req_lsu;

    always_comb begin
        o_gnt_exu = 1'b0;
        o_gnt_lsu = 1'b0;
        if (w_tie) begin
            o_gnt_exu = (r_ptr == REQ_EXU);
            o_gnt_lsu = (r_ptr == REQ_LSU);
        end else begin
            o_gnt_exu = i_req_exu;
            o_gnt_lsu = i_req_lsu;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= REQ_EXU;
        end else if (w_tie) begin
            r_ptr <= (r_ptr == REQ_EXU) ? REQ_LSU : REQ_EXU;
        end
    end

endmodule

// File: rtl/ysyx_22041461_rf_sched.sv
// Register-file write scheduler: busy-bit scoreboard gating decode issue, and
// EXU/LSU writeback arbitration onto one registered write port.
// Define YSYX_22041461_RF_SCHED_BYPASS_EN to let issue see the port's clear this cycle.
module ysyx_22041461_rf_sched
    import ysyx_22041461_rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [AW-1:0]     id_rs1,
    input  logic [AW-1:0]     id_rs2,
    input  logic [AW-1:0]     id_rd,
    input  logic              id_rd_wen,
    input  logic              exu_valid,
    output logic              exu_ready,
    input  logic [AW-1:0]     exu_rd,
    input  logic [XLEN-1:0]   exu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [AW-1:0]     lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    output logic [3:0]        rf_sel,
    output logic [AW-1:0]     rf_rd,
    output logic [XLEN-1:0]   rf_dest,
    output logic [NREG-1:0]   busy,
    output logic              sb_err,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [NREG-1:0]  r_busy;
    logic [3:0]       r_rf_sel;
    logic [AW-1:0]    r_rf_rd;
    logic [XLEN-1:0]  r_rf_dest;
    logic             r_sb_err;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [NREG-1:0]  w_clr_vec;
    logic [NREG-1:0]  w_set_vec;
    logic [NREG-1:0]  w_busy_eff;
    logic             w_haz;
    logic             w_issue;
    logic             w_gnt_exu;
    logic             w_gnt_lsu;
    logic             w_gnt_any;
    logic [AW-1:0]    w_wb_rd;
    logic [XLEN-1:0]  w_wb_data;

    // The port's pending write retires its busy bit at the next edge.
    assign w_clr_vec = (r_rf_sel == RF_SEL_DEST) ? (NREG'(1) << r_rf_rd) : '0;

`ifdef YSYX_22041461_RF_SCHED_BYPASS_EN
    assign w_busy_eff = r_busy & ~w_clr_vec;
`else
    assign w_busy_eff = r_busy;
`endif

    assign w_haz    = w_busy_eff[id_rs1] | w_busy_eff[id_rs2] | (id_rd_wen & w_busy_eff[id_rd]);
    assign id_ready = !w_haz;
    assign w_issue  = id_valid && !w_haz;
    assign w_set_vec = (w_issue && id_rd_wen && (id_rd != '0)) ? (NREG'(1) << id_rd) : '0;

    // Requests are masked during reset so no requester sees a transfer that gets discarded.
    ysyx_22041461_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req_exu (exu_valid && !rst),
        .i_req_lsu (lsu_valid && !rst),
        .o_gnt_exu (w_gnt_exu),
        .o_gnt_lsu (w_gnt_lsu)
    );

    assign exu_ready = w_gnt_exu;
    assign lsu_ready = w_gnt_lsu;
    assign w_gnt_any = w_gnt_exu || w_gnt_lsu;
    assign w_wb_rd   = w_gnt_exu ? exu_rd   : lsu_rd;
    assign w_wb_data = w_gnt_exu ? exu_data : lsu_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= '0;
            r_rf_sel    <= RF_SEL_HOLD;
            r_rf_rd     <= '0;
            r_rf_dest   <= '0;
            r_sb_err    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            // Set is applied after clear so a same-index issue (bypass only) keeps the bit.
            r_busy <= (r_busy & ~w_clr_vec) | w_set_vec;

            r_rf_sel <= RF_SEL_HOLD;
            if (w_gnt_any && (w_wb_rd != '0)) begin
                r_rf_sel  <= RF_SEL_DEST;
                r_rf_rd   <= w_wb_rd;
                r_rf_dest <= w_wb_data;
                if (!r_busy[w_wb_rd]) begin
                    r_sb_err <= 1'b1;
                end
            end

            if (id_valid && w_haz && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign rf_sel    = r_rf_sel;
    assign rf_rd     = r_rf_rd;
    assign rf_dest   = r_rf_dest;
    assign busy      = r_busy;
    assign sb_err    = r_sb_err;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ysyx_22041461_rf_sched.sv
// Self-checking bench for ysyx_22041461_rf_sched: directed scenarios plus a
// randomized run against a behavioural scoreboard model.
module tb_ysyx_22041461_rf_sched;

    localparam bit BYPASS =
`ifdef YSYX_22041461_RF_SCHED_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rd_wen;
    logic        exu_valid, exu_ready;
    logic [4:0]  exu_rd;
    logic [63:0] exu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_data;
    logic [3:0]  rf_sel;
    logic [4:0]  rf_rd;
    logic [63:0] rf_dest;
    logic [31:0] busy;
    logic        sb_err;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit [31:0] m_busy;
    bit        m_sel;
    bit [4:0]  m_rd;
    bit [63:0] m_dest;
    bit        m_err;
    bit        m_ptr_lsu;
    bit [31:0] m_stall;

    ysyx_22041461_rf_sched dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_wen(id_rd_wen),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_sel(rf_sel), .rf_rd(rf_rd), .rf_dest(rf_dest),
        .busy(busy), .sb_err(sb_err), .stall_cnt(stall_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A register blocks issue if it has an outstanding writer, unless (bypass) it
    // is being written back this very cycle.
    function automatic bit blocked(int r);
        if (r == 0) return 1'b0;
        if (!m_busy[r]) return 1'b0;
        if (BYPASS && m_sel && (m_rd == r)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_ready();
        return !(blocked(id_rs1) || blocked(id_rs2) || (id_rd_wen && blocked(id_rd)));
    endfunction

    function automatic bit model_gnt_exu();
        if (rst) return 1'b0;
        if (exu_valid && lsu_valid) return !m_ptr_lsu;
        return exu_valid;
    endfunction

    function automatic bit model_gnt_lsu();
        if (rst) return 1'b0;
        if (exu_valid && lsu_valid) return m_ptr_lsu;
        return lsu_valid;
    endfunction

    // Driver tasks
    task automatic set_id(input bit v, input int rs1, input int rs2, input int rd, input bit wen);
        id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd); id_rd_wen = wen;
    endtask

    task automatic set_exu(input bit v, input int rd, input logic [63:0] d);
        exu_valid = v; exu_rd = 5'(rd); exu_data = d;
    endtask

    task automatic set_lsu(input bit v, input int rd, input logic [63:0] d);
        lsu_valid = v; lsu_rd = 5'(rd); lsu_data = d;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0);
        set_exu(0, 0, 64'd0);
        set_lsu(0, 0, 64'd0);
    endtask

    // Advance one clock and step the model with the inputs that were present at the edge.
    task automatic cycle();
        bit rdy, ge, gl;
        bit [31:0] nb;
        int wrd;
        logic [63:0] wd;
        rdy = model_ready();
        ge  = model_gnt_exu();
        gl  = model_gnt_lsu();
        @(posedge clk);
        if (rst) begin
            m_busy = '0; m_sel = 0; m_rd = '0; m_dest = '0;
            m_err = 0; m_ptr_lsu = 0; m_stall = '0;
        end else begin
            nb = m_busy;
            if (m_sel) nb[m_rd] = 1'b0;
            if (id_valid && rdy && id_rd_wen && id_rd != 0) nb[id_rd] = 1'b1;
            m_sel = 1'b0;
            if (ge || gl) begin
                wrd = ge ? int'(exu_rd) : int'(lsu_rd);
                wd  = ge ? exu_data : lsu_data;
                if (wrd != 0) begin
                    if (!m_busy[wrd]) m_err = 1'b1;
                    m_sel  = 1'b1;
                    m_rd   = 5'(wrd);
                    m_dest = wd;
                end
            end
            if (exu_valid && lsu_valid) m_ptr_lsu = !m_ptr_lsu;
            if (id_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            m_busy = nb;
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy); end
        checks++; if (rf_sel !== 4'b0000) begin errors++; $display("FAIL reset_rf_sel got=%b exp=0000", rf_sel); end
        checks++; if (rf_rd !== 5'd0 || rf_dest !== 64'd0) begin errors++; $display("FAIL reset_rf_port got rd=%0d dest=%h exp 0/0", rf_rd, rf_dest); end
        checks++; if (sb_err !== 1'b0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_err_stall got err=%b stall=%0d exp 0/0", sb_err, stall_cnt); end
    endtask

    task automatic test_raw_stall();
        do_reset();
        set_id(1, 0, 0, 5, 1); #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL raw_first_issue got=%b exp=1", id_ready); end
        cycle();
        set_id(1, 5, 0, 6, 1); #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL raw_stall got=%b exp=0", id_ready); end
        cycle(); cycle(); cycle();
        checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL raw_stall_cnt got=%0d exp=3", stall_cnt); end
        set_exu(1, 5, 64'hAB); #1;
        checks++; if (exu_ready !== 1'b1) begin errors++; $display("FAIL raw_exu_grant got=%b exp=1", exu_ready); end
        cycle();
        set_exu(0, 0, 64'd0); #1;
        checks++; if (rf_sel !== 4'b0001 || rf_rd !== 5'd5 || rf_dest !== 64'hAB) begin
            errors++; $display("FAIL raw_wport got sel=%b rd=%0d dest=%h exp 0001/5/ab", rf_sel, rf_rd, rf_dest); end
        checks++; if (id_ready !== BYPASS) begin errors++; $display("FAIL raw_ready_n1 got=%b exp=%b", id_ready, BYPASS); end
        if (!BYPASS) begin
            cycle();
            checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL raw_ready_n2 got=%b exp=1", id_ready); end
        end
        cycle();
        set_id(0, 0, 0, 0, 0); #1;
        checks++; if (busy !== 32'h0000_0040) begin errors++; $display("FAIL raw_busy_after got=%h exp=00000040", busy); end
    endtask

    task automatic test_tie();
        do_reset();
        set_id(1, 0, 0, 3, 1); cycle();
        set_id(1, 0, 0, 4, 1); cycle();
        set_id(0, 0, 0, 0, 0);
        set_exu(1, 3, 64'h33); set_lsu(1, 4, 64'h44); #1;
        checks++; if (exu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            errors++; $display("FAIL tie_first got exu=%b lsu=%b exp 1/0", exu_ready, lsu_ready); end
        cycle();
        set_exu(0, 0, 64'd0); #1;
        checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL tie_lsu_next got=%b exp=1", lsu_ready); end
        checks++; if (rf_sel !== 4'b0001 || rf_rd !== 5'd3 || rf_dest !== 64'h33) begin
            errors++; $display("FAIL tie_wport_exu got sel=%b rd=%0d dest=%h exp 0001/3/33", rf_sel, rf_rd, rf_dest); end
        cycle();
        set_lsu(0, 0, 64'd0); #1;
        checks++; if (rf_sel !== 4'b0001 || rf_rd !== 5'd4 || rf_dest !== 64'h44) begin
            errors++; $display("FAIL tie_wport_lsu got sel=%b rd=%0d dest=%h exp 0001/4/44", rf_sel, rf_rd, rf_dest); end
        set_exu(1, 0, 64'h1); set_lsu(1, 0, 64'h2); #1;
        checks++; if (exu_ready !== 1'b0 || lsu_ready !== 1'b1) begin
            errors++; $display("FAIL tie_second got exu=%b lsu=%b exp 0/1", exu_ready, lsu_ready); end
        cycle();
        idle(); #1;
        checks++; if (busy !== 32'd0 || sb_err !== 1'b0) begin
            errors++; $display("FAIL tie_final got busy=%h err=%b exp 0/0", busy, sb_err); end
    endtask

    task automatic test_rd0();
        set_exu(1, 0, 64'hFF); #1;
        checks++; if (exu_ready !== 1'b1) begin errors++; $display("FAIL rd0_grant got=%b exp=1", exu_ready); end
        cycle();
        set_exu(0, 0, 64'd0); #1;
        checks++; if (rf_sel !== 4'b0000 || rf_rd !== 5'd4 || rf_dest !== 64'h44) begin
            errors++; $display("FAIL rd0_port got sel=%b rd=%0d dest=%h exp 0000/4/44", rf_sel, rf_rd, rf_dest); end
        checks++; if (busy !== 32'd0 || sb_err !== 1'b0) begin
            errors++; $display("FAIL rd0_sb got busy=%h err=%b exp 0/0", busy, sb_err); end
    endtask

    task automatic test_err();
        set_exu(1, 7, 64'h77); cycle();
        set_exu(0, 0, 64'd0); #1;
        checks++; if (rf_sel !== 4'b0001 || rf_rd !== 5'd7 || rf_dest !== 64'h77) begin
            errors++; $display("FAIL err_write got sel=%b rd=%0d dest=%h exp 0001/7/77", rf_sel, rf_rd, rf_dest); end
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", sb_err); end
        cycle(); cycle();
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", sb_err); end
    endtask

    task automatic test_waw();
        do_reset();
        set_id(1, 0, 0, 9, 1); cycle();
        set_id(1, 0, 9, 9, 1); #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL waw_stall got=%b exp=0", id_ready); end
        set_exu(1, 9, 64'h99); cycle();
        set_exu(0, 0, 64'd0); #1;
        checks++; if (id_ready !== BYPASS) begin errors++; $display("FAIL waw_clear_cycle got=%b exp=%b", id_ready, BYPASS); end
        if (!BYPASS) cycle();
        cycle();
        set_id(0, 0, 0, 0, 0); #1;
        checks++; if (busy !== 32'h0000_0200) begin errors++; $display("FAIL waw_busy9 got=%h exp=00000200", busy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_id(1, 0, 0, 4, 1); cycle();
        set_id(1, 0, 0, 8, 1); cycle();
        set_id(1, 4, 0, 0, 0); cycle();
        checks++; if (busy !== 32'h0000_0110) begin errors++; $display("FAIL rstmid_busy_pre got=%h exp=00000110", busy); end
        rst = 1'b1; set_lsu(1, 4, 64'hDEAD); #1;
        checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL rstmid_no_grant got=%b exp=0", lsu_ready); end
        cycle();
        rst = 1'b0; idle(); #1;
        checks++; if (busy !== 32'd0 || rf_sel !== 4'b0000 || stall_cnt !== 32'd0) begin
            errors++; $display("FAIL rstmid_after got busy=%h sel=%b stall=%0d exp 0/0000/0", busy, rf_sel, stall_cnt); end
    endtask

    task automatic test_random();
        bit e_hold, l_hold;
        do_reset();
        e_hold = 0; l_hold = 0;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            set_id($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 1));
            if (!e_hold) set_exu($urandom_range(0, 1), $urandom_range(0, 7), {$urandom, $urandom});
            if (!l_hold) set_lsu($urandom_range(0, 1), $urandom_range(0, 7), {$urandom, $urandom});
            #1;
            checks++; if (id_ready !== model_ready()) begin
                errors++; $display("FAIL rnd_id_ready it=%0d got=%b exp=%b", i, id_ready, model_ready()); end
            checks++; if (exu_ready !== model_gnt_exu() || lsu_ready !== model_gnt_lsu()) begin
                errors++; $display("FAIL rnd_grant it=%0d got exu=%b lsu=%b exp %b/%b", i,
                                   exu_ready, lsu_ready, model_gnt_exu(), model_gnt_lsu()); end
            e_hold = exu_valid && !model_gnt_exu() && !rst;
            l_hold = lsu_valid && !model_gnt_lsu() && !rst;
            cycle();
            checks++; if (busy !== m_busy || sb_err !== m_err || stall_cnt !== m_stall) begin
                errors++; $display("FAIL rnd_state it=%0d got busy=%h err=%b stall=%0d exp %h/%b/%0d", i,
                                   busy, sb_err, stall_cnt, m_busy, m_err, m_stall); end
            checks++; if (rf_sel !== {3'b000, m_sel} || (m_sel && (rf_rd !== m_rd || rf_dest !== m_dest))) begin
                errors++; $display("FAIL rnd_wport it=%0d got sel=%b rd=%0d dest=%h exp sel=%b rd=%0d dest=%h", i,
                                   rf_sel, rf_rd, rf_dest, m_sel, m_rd, m_dest); end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_raw_stall();
        test_tie();
        test_rd0();
        test_err();
        test_waw();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22041461_rf_sched.md
Name: ysyx_22041461_rf_sched

Overview:
- Register-file write scheduler and scoreboard for the pipelined NPC core.
- Gates decode issue on RAW/WAW hazards against in-flight destination registers.
- Arbitrates two writeback requesters (EXU: ALU/CSR results; LSU: load data) onto the single register-file write port.
- Drives that port through the file's select/rd/dest inputs.

Parameters:
XLEN, 64, data width
NREG, 32, architectural register count
AW, 5, register index width
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
id_valid  in  1  decode has an instruction to issue
id_ready  out  1  issue accepted this cycle
id_rs1  in  AW  source 1 index
id_rs2  in  AW  source 2 index
id_rd  in  AW  destination index
id_rd_wen  in  1  instruction writes rd
exu_valid  in  1  EXU writeback request
exu_ready  out  1  EXU granted
exu_rd  in  AW  EXU destination
exu_data  in  XLEN  EXU result
lsu_valid  in  1  LSU writeback request
lsu_ready  out  1  LSU granted
lsu_rd  in  AW  LSU destination
lsu_data  in  XLEN  LSU result
rf_sel  out  4  register-file select: 4'b0001 write dest, 4'b0000 hold
rf_rd  out  AW  register-file write index
rf_dest  out  XLEN  register-file write data
busy  out  NREG  scoreboard vector
sb_err  out  1  sticky protocol error
stall_cnt  out  CNT_W  cycles with id_valid && !id_ready

Behaviour:
- Reset (synchronous, rst=1 at posedge): busy=0, rf_sel=0000, rf_rd=0, rf_dest=0, rr_ptr=EXU, sb_err=0, stall_cnt=0. Reset mid-operation discards all in-flight state. No writes are issued on the following cycle.
- Hazard: haz = busy[id_rs1] | busy[id_rs2] | (id_rd_wen & busy[id_rd]). Index 0 is never busy.
- id_ready = !haz, combinational.
- Issue fires when id_valid && id_ready. If id_rd_wen and id_rd != 0, busy[id_rd] is set at the clock edge.
- Arbitration (combinational grant):
  - Only one requester valid: that requester is granted.
  - Both valid: rr_ptr's requester is granted. rr_ptr then flips to the other requester.
  - Single grants leave rr_ptr unchanged.
  - exu_ready/lsu_ready are the grants. A transfer completes when valid && ready.
  - Requesters hold rd/data stable while valid && !ready.
- Write port (registered, latency 1):
  - Grant in cycle N drives rf_sel=0001, rf_rd, rf_dest during cycle N+1.
  - The register file captures at end of N+1.
  - busy[rf_rd] clears at the same edge.
  - A consumer reading that register first issues in N+2.
  - With no grant, rf_sel=0000 and rf_rd/rf_dest hold their previous values.
- Writeback with rd=0: granted and consumed, rf_sel stays 0000, no scoreboard change.
- Writeback to a non-busy rd != 0: the write still occurs and sb_err sets (sticky until reset).
- Simultaneous issue set and write-port clear: index differs by construction, because WAW stalls. Both take effect.
- stall_cnt saturates at all-ones.

Optional Feature:
- Macro: YSYX_22041461_RF_SCHED_BYPASS_EN.
- Defined:
  - The hazard check uses busy & ~clr_vec, where clr_vec is the one-hot of rf_rd when rf_sel=0001.
  - An instruction reading a register written in the current cycle issues the same cycle, one cycle earlier than without the macro.
  - If the issue rd equals the clearing index, the set wins and busy stays 1.
- Undefined: registered busy only, as above.

Decomposition:
- Package ysyx_22041461_rf_pkg holds:
  - RF_SEL_HOLD=4'b0000 and RF_SEL_DEST=4'b0001.
  - XLEN, NREG, AW.
  - Requester enum {REQ_EXU, REQ_LSU}.
- One natural sub-module: ysyx_22041461_rr_arb2, a two-way round-robin arbiter with pointer register.
- Scoreboard and write-port register stay in the top.

Test Plan:
- Issue rd=5 (wen), then issue rs1=5 -> id_ready=0; stall_cnt counts. EXU writes rd=5 data 0xAB -> rf_sel=0001, rf_rd=5, rf_dest=0xAB next cycle. Dependent issues two cycles after grant (one with BYPASS_EN).
- Issue rd=3 then rd=4. EXU(rd=3) and LSU(rd=4) valid together after reset -> EXU granted first, LSU next cycle. rr_ptr=LSU wins the next tie.
- Writeback rd=0 data 0xFF -> granted, rf_sel=0000, busy unchanged, sb_err=0.
- Writeback rd=7 when busy[7]=0 -> write performed, sb_err=1 until rst.
- Issue rd=9 with rs2=9 pending from a prior instruction -> stalled for WAW+RAW until clear. With BYPASS_EN, issue in the clear cycle leaves busy[9]=1.
- Assert rst with busy=0x0000_0110 and LSU valid -> next cycle busy=0, rf_sel=0000, no grant-side write, stall_cnt=0.
